// File: rtl/pic_data_bus_buffer_pkg.sv
// Shared types and sizing helpers for the PIC data bus buffer.
package pic_bus_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_REQ   = 2'd1,
    R_DRIVE = 2'd2
  } rd_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pic_data_bus_buffer_if.sv
// CPU-pin and control-side signals of the PIC data bus buffer.
interface pic_data_bus_buffer_if import pic_bus_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] Ds_IN;
  logic [DATA_W-1:0] Ds_OUT;
  logic              Ds_OE;
  logic              RD_flag;
  logic              WR_flag;
  logic [DATA_W-1:0] Ds_to_Control;
  logic              wr_valid;
  logic              wr_ready;
  logic              RD_flag_control;
  logic [DATA_W-1:0] Ds_from_control;
  logic              rd_valid;
  logic              ovf;
  logic              rd_err;
  logic              err_clr;

  // slave = the buffer itself; master = its environment (CPU pins + control).
  modport slave (
    input  Ds_IN, RD_flag, WR_flag, wr_ready, Ds_from_control, rd_valid, err_clr,
    output Ds_OUT, Ds_OE, Ds_to_Control, wr_valid, RD_flag_control, ovf, rd_err
  );

  modport master (
    output Ds_IN, RD_flag, WR_flag, wr_ready, Ds_from_control, rd_valid, err_clr,
    input  Ds_OUT, Ds_OE, Ds_to_Control, wr_valid, RD_flag_control, ovf, rd_err
  );
endinterface

// File: rtl/pic_data_bus_buffer_wr_fifo.sv
// Small synchronous write FIFO; when empty the head output holds the last popped word.
module bus_wr_fifo import pic_bus_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CW        = cnt_w(FIFO_DEPTH),
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] head_q;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is fine when a pop frees the slot in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? head_q : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        head_q   <= mem[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pic_data_bus_buffer.sv
// PIC data bus buffer: CPU writes queue into a FIFO for control; CPU reads fetch one word from control.
//   state   | meaning
//   R_IDLE  | no read in progress, waiting for an RD rise
//   R_REQ   | request issued, waiting for rd_valid while RD is held
//   R_DRIVE | returned data driven to the pins until RD falls
module pic_data_bus_buffer import pic_bus_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic                  clk,
  input logic                  rst_n,
  pic_data_bus_buffer_if.slave bus
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  rd_state_t         state_q, state_d;
  logic              rd_prev_q, wr_prev_q;
  logic              rd_rise, wr_rise;
  logic              req_q, req_d;
  logic              load_out, rd_err_set;
  logic [DATA_W-1:0] ds_out_q;
  logic              ovf_q, rd_err_q;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, ovf_set;
  logic [CW-1:0]     fifo_count;

  assign rd_rise = bus.RD_flag & ~rd_prev_q;
  assign wr_rise = bus.WR_flag & ~wr_prev_q;

  assign fifo_pop  = ~fifo_empty & bus.wr_ready;
  assign fifo_push = wr_rise & ((fifo_count != CW'(FIFO_DEPTH)) | fifo_pop);
  assign ovf_set   = wr_rise & fifo_full & ~fifo_pop;

  bus_wr_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (bus.Ds_IN),
    .pop   (fifo_pop),
    .dout  (bus.Ds_to_Control),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      req_q     <= 1'b0;
      ds_out_q  <= '0;
      ovf_q     <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_prev_q <= bus.RD_flag;
      wr_prev_q <= bus.WR_flag;
      req_q     <= req_d;
      if (load_out) ds_out_q <= bus.Ds_from_control;
      // Set has priority over clear so an error in the clearing cycle is not lost.
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (rd_err_set)       rd_err_q <= 1'b1;
      else if (bus.err_clr) rd_err_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    load_out   = 1'b0;
    rd_err_set = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (rd_rise) begin
          state_d = R_REQ;
          req_d   = 1'b1;
        end
      end
      R_REQ: begin
        if (!bus.RD_flag) begin
          state_d    = R_IDLE;
          rd_err_set = 1'b1;
        end else if (bus.rd_valid) begin
          state_d  = R_DRIVE;
          load_out = 1'b1;
        end
      end
      R_DRIVE: begin
        if (!bus.RD_flag) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign bus.Ds_OUT          = ds_out_q;
  assign bus.Ds_OE           = (state_q == R_DRIVE);
  assign bus.RD_flag_control = req_q;
  assign bus.wr_valid        = ~fifo_empty;
  assign bus.ovf             = ovf_q;
  assign bus.rd_err          = rd_err_q;

endmodule

// File: tb/tb_pic_data_bus_buffer.sv
// Directed bench for pic_data_bus_buffer (DATA_W=8, FIFO_DEPTH=4).
module tb_pic_data_bus_buffer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pic_data_bus_buffer_if #(.DATA_W(8)) bus ();

  pic_data_bus_buffer #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q [$];
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.Ds_IN = '0;
    bus.RD_flag = 1'b0;
    bus.WR_flag = 1'b0;
    bus.wr_ready = 1'b0;
    bus.Ds_from_control = '0;
    bus.rd_valid = 1'b0;
    bus.err_clr = 1'b0;
    #12;
    chk("rst_oe", bus.Ds_OE, 0);
    chk("rst_out", bus.Ds_OUT, 0);
    chk("rst_head", bus.Ds_to_Control, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_req", bus.RD_flag_control, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    rst_n = 1'b1;
    tick();

    // Single write, latency 1, then one pop empties it.
    bus.WR_flag = 1'b1; bus.Ds_IN = 8'hF0;
    tick();
    chk("wr1_valid", bus.wr_valid, 1);
    chk("wr1_head", bus.Ds_to_Control, 8'hF0);
    bus.WR_flag = 1'b0; bus.wr_ready = 1'b1;
    tick();
    chk("wr1_popped", bus.wr_valid, 0);
    chk("wr1_hold", bus.Ds_to_Control, 8'hF0);
    bus.wr_ready = 1'b0;
    tick();

    // Overflow: five writes into a depth-4 FIFO.
    for (int i = 1; i <= 5; i++) begin
      bus.WR_flag = 1'b1; bus.Ds_IN = 8'(i);
      tick();
      if (i == 4) chk("ovf_not_yet", bus.ovf, 0);
      bus.WR_flag = 1'b0;
      tick();
    end
    chk("ovf_set", bus.ovf, 1);
    bus.wr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain_valid", bus.wr_valid, 1);
      chk("ovf_drain_data", bus.Ds_to_Control, 32'(k));
      tick();
    end
    chk("ovf_drained", bus.wr_valid, 0);
    bus.wr_ready = 1'b0; bus.err_clr = 1'b1;
    tick();
    chk("ovf_clr", bus.ovf, 0);
    bus.err_clr = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    exp_q = '{8'h22, 8'h33, 8'h44, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      bus.WR_flag = 1'b1; bus.Ds_IN = 8'h11 * 8'(i + 1);
      tick();
      bus.WR_flag = 1'b0;
      tick();
    end
    bus.WR_flag = 1'b1; bus.Ds_IN = 8'hAA; bus.wr_ready = 1'b1;
    tick();
    chk("fullpop_no_ovf", bus.ovf, 0);
    chk("fullpop_head", bus.Ds_to_Control, 8'h22);
    bus.WR_flag = 1'b0; bus.wr_ready = 1'b0;
    tick();
    // Still full: a further write must be dropped.
    bus.WR_flag = 1'b1; bus.Ds_IN = 8'hBB;
    tick();
    chk("fullpop_still_full", bus.ovf, 1);
    bus.WR_flag = 1'b0; bus.wr_ready = 1'b1;
    foreach (exp_q[k]) begin
      chk("fullpop_drain", bus.Ds_to_Control, 32'(exp_q[k]));
      tick();
    end
    chk("fullpop_empty", bus.wr_valid, 0);
    bus.wr_ready = 1'b0; bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // Normal read, data returned while RD is held.
    bus.RD_flag = 1'b1;
    tick();
    chk("rd_req_pulse", bus.RD_flag_control, 1);
    tick();
    chk("rd_req_single", bus.RD_flag_control, 0);
    chk("rd_oe_wait", bus.Ds_OE, 0);
    tick();
    bus.rd_valid = 1'b1; bus.Ds_from_control = 8'h0F;
    tick();
    chk("rd_oe_on", bus.Ds_OE, 1);
    chk("rd_out", bus.Ds_OUT, 8'h0F);
    bus.rd_valid = 1'b1; bus.Ds_from_control = 8'h55;
    tick();
    bus.rd_valid = 1'b0;
    tick();
    chk("rd_out_hold", bus.Ds_OUT, 8'h0F);
    chk("rd_oe_hold", bus.Ds_OE, 1);
    bus.RD_flag = 1'b0;
    tick();
    chk("rd_oe_off", bus.Ds_OE, 0);
    chk("rd_out_kept", bus.Ds_OUT, 8'h0F);
    chk("rd_no_err", bus.rd_err, 0);

    // Read strobe ends before data arrives.
    bus.RD_flag = 1'b1;
    tick();
    tick();
    bus.RD_flag = 1'b0; bus.rd_valid = 1'b1; bus.Ds_from_control = 8'hFF;
    tick();
    chk("late_err", bus.rd_err, 1);
    chk("late_oe", bus.Ds_OE, 0);
    tick();
    chk("late_out", bus.Ds_OUT, 8'h0F);
    chk("late_oe2", bus.Ds_OE, 0);
    bus.rd_valid = 1'b0; bus.err_clr = 1'b1;
    tick();
    chk("rd_err_clr", bus.rd_err, 0);
    bus.err_clr = 1'b0;

    // Set beats clear in the same cycle.
    bus.RD_flag = 1'b1;
    tick();
    bus.RD_flag = 1'b0; bus.err_clr = 1'b1;
    tick();
    chk("set_wins", bus.rd_err, 1);
    tick();
    chk("clr_after", bus.rd_err, 0);
    bus.err_clr = 1'b0;

    // Simultaneous RD and WR rises, then reset while driving.
    bus.RD_flag = 1'b1; bus.WR_flag = 1'b1; bus.Ds_IN = 8'h77;
    tick();
    chk("sim_req", bus.RD_flag_control, 1);
    chk("sim_wr", bus.Ds_to_Control, 8'h77);
    chk("sim_no_err", bus.rd_err, 0);
    bus.WR_flag = 1'b0;
    tick();
    bus.WR_flag = 1'b1; bus.Ds_IN = 8'h88;
    bus.rd_valid = 1'b1; bus.Ds_from_control = 8'hFF;
    tick();
    chk("mid_oe", bus.Ds_OE, 1);
    chk("mid_out", bus.Ds_OUT, 8'hFF);
    bus.rd_valid = 1'b0; bus.WR_flag = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", bus.Ds_OUT, 0);
    chk("arst_oe", bus.Ds_OE, 0);
    chk("arst_head", bus.Ds_to_Control, 0);
    chk("arst_wr_valid", bus.wr_valid, 0);
    chk("arst_ovf_err", {bus.ovf, bus.rd_err, bus.RD_flag_control}, 0);
    bus.RD_flag = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_empty", bus.wr_valid, 0);
    chk("post_rst_oe", bus.Ds_OE, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pic_data_bus_buffer.md
Name: pic_data_bus_buffer

Overview:
Clocked, parametrised data bus buffer for the PIC, placed between the CPU data pins and the read/write and control logic. Write strobes capture CPU data into a small write FIFO, which the control logic drains with a valid/ready handshake. Read strobes issue a single request pulse to control, wait for the returned data, then hold and drive it to the CPU for the rest of the read strobe. Tri-state is expressed as an output-enable; the top level builds the pad.

Parameters:
DATA_W, 8, data bus width in bits (>=1)
FIFO_DEPTH, 4, write FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
Ds_IN  in  DATA_W  data from CPU pins
Ds_OUT  out  DATA_W  registered read data to CPU pins
Ds_OE  out  1  pad output enable; 1 = drive Ds_OUT
RD_flag  in  1  read strobe level from read/write logic, synchronous to clk
WR_flag  in  1  write strobe level from read/write logic, synchronous to clk
Ds_to_Control  out  DATA_W  write FIFO head data
wr_valid  out  1  FIFO non-empty
wr_ready  in  1  control accepts head; pop when wr_valid & wr_ready
RD_flag_control  out  1  one-cycle read request pulse to control
Ds_from_control  in  DATA_W  read data from control
rd_valid  in  1  Ds_from_control valid
ovf  out  1  sticky: write dropped because FIFO was full
rd_err  out  1  sticky: read strobe ended before data returned
err_clr  in  1  clears ovf and rd_err

Behaviour:
- Reset (rst_n low, any time, including mid-transfer): outputs Ds_OUT=0, Ds_OE=0, Ds_to_Control=0, wr_valid=0, RD_flag_control=0, ovf=0, rd_err=0. FIFO is emptied, the read FSM goes to R_IDLE, and the strobe history registers are set to 0.
- Edge detect: the block registers the previous values of RD_flag and WR_flag. A rise is current=1 & prev=0. A strobe that is already high when reset is released counts as a rise on the first clock.
- Write path: a WR rise pushes Ds_IN as sampled on that clock edge. The entry is visible on Ds_to_Control/wr_valid on the next cycle (latency 1).
- A pop happens when wr_valid & wr_ready; the next entry appears on the following cycle.
- Count width is $clog2(FIFO_DEPTH+1). Pointers wrap modulo FIFO_DEPTH.
- Full with no pop on a WR rise: the write is dropped and ovf is set.
- Full with a pop in the same cycle as a WR rise: the push is accepted and the count is unchanged.
- Empty: wr_ready is ignored. Ds_to_Control holds the last head value.
- Read FSM states: R_IDLE, R_REQ, R_DRIVE.
- R_IDLE: on an RD rise, go to R_REQ and set RD_flag_control=1 for exactly one cycle, starting the cycle after the edge.
- R_REQ, rd_valid=1 while RD_flag=1: latch Ds_from_control into Ds_OUT and go to R_DRIVE. Ds_OE=1 from the next cycle.
- R_REQ, RD_flag=0: set rd_err and go to R_IDLE. Ds_OE stays 0. A rd_valid in that same cycle is ignored.
- R_DRIVE: Ds_OE=1 and Ds_OUT is held while RD_flag=1. When RD_flag=0, go to R_IDLE; Ds_OE=0 the next cycle. Ds_OUT keeps its value.
- rd_valid is ignored in R_IDLE and R_DRIVE.
- A new RD rise is only recognised in R_IDLE.
- Simultaneous RD and WR rises: both paths act independently; no error is flagged.
- err_clr: clears both sticky flags. If a set event occurs in the same cycle, the set wins.

Decomposition:
- Package pic_bus_pkg holds:
  - the rd_state_t enum (R_IDLE, R_REQ, R_DRIVE);
  - the default DATA_W and FIFO_DEPTH constants;
  - a count-width helper function.
- Sub-module bus_wr_fifo is a synchronous FIFO with push, pop, full, empty, count and an async active-low reset, parametrised on DATA_W and FIFO_DEPTH.
- The read FSM, edge detectors and sticky flags live in the top module.

Test Plan:
- Single write: WR pulse with Ds_IN=8'hF0, wr_ready=0 -> the cycle after the edge, wr_valid=1 and Ds_to_Control=8'hF0. Then wr_ready=1 for one cycle -> wr_valid=0.
- Overflow: 5 WR pulses (8'h01..8'h05) with wr_ready=0 and depth 4 -> ovf=1 and 4 entries held. Draining gives 01,02,03,04. err_clr -> ovf=0.
- Full plus simultaneous pop: FIFO full, a WR rise of 8'hAA coincides with a pop -> no ovf, count stays 4, and 8'hAA is last out.
- Normal read: RD rises -> RD_flag_control is a 1-cycle pulse. Return rd_valid with 8'h0F after 3 cycles -> Ds_OE=1 and Ds_OUT=8'h0F until RD falls, then Ds_OE=0 one cycle later.
- Late data: RD rises, then falls before rd_valid -> rd_err=1 and Ds_OE never asserts. A later rd_valid with 8'hFF leaves Ds_OUT unchanged.
- Reset mid-read: assert rst_n=0 in R_DRIVE with Ds_OUT=8'hFF and FIFO holding 2 entries -> all outputs 0 immediately (async). After release, the FIFO is empty.
